// File: rtl/sysid_check_master.sv
// Avalon-MM master that reads the sysid slave (ID, timestamp) after a start pulse
// and checks both words against build-time constants, holding sticky results.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'h5503E08A,
  parameter logic [31:0] EXPECTED_TS    = 32'h00000000,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  localparam int          DATA_W   = 32;
  // Abort on the stall cycle that would be the TIMEOUT_CYCLES-th one.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

  state_t              state, state_nxt;
  logic [15:0]         stall_cnt, stall_cnt_nxt;
  logic                busy_nxt, done_nxt, pass_nxt;
  logic                id_mm_nxt, ts_mm_nxt, tmo_nxt;
  logic                read_nxt, addr_nxt;
  logic [DATA_W-1:0]   id_nxt, ts_nxt;

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    pass_nxt      = pass;
    id_mm_nxt     = id_mismatch;
    ts_mm_nxt     = ts_mismatch;
    tmo_nxt       = timeout;
    id_nxt        = id_value;
    ts_nxt        = ts_value;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = RD_ID;
          stall_cnt_nxt = '0;
          pass_nxt      = 1'b0;
          id_mm_nxt     = 1'b0;
          ts_mm_nxt     = 1'b0;
          tmo_nxt       = 1'b0;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          id_nxt        = avm_readdata;
          id_mm_nxt     = (avm_readdata != EXPECTED_ID);
          stall_cnt_nxt = '0;
          state_nxt     = RD_TS;
        end else if (stall_cnt == TMO_LAST) begin
          tmo_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          stall_cnt_nxt = stall_cnt + 16'd1;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_nxt    = avm_readdata;
          ts_mm_nxt = (avm_readdata != EXPECTED_TS);
          state_nxt = DONE;
        end else if (stall_cnt == TMO_LAST) begin
          tmo_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          stall_cnt_nxt = stall_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    read_nxt = (state_nxt == RD_ID) || (state_nxt == RD_TS);
    addr_nxt = (state_nxt == RD_TS);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    if ((state_nxt == DONE) && (state != DONE))
      pass_nxt = !tmo_nxt && !id_mm_nxt && !(CHECK_TS && ts_mm_nxt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      stall_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
    end else begin
      state       <= state_nxt;
      stall_cnt   <= stall_cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pass        <= pass_nxt;
      id_mismatch <= id_mm_nxt;
      ts_mismatch <= ts_mm_nxt;
      timeout     <= tmo_nxt;
      id_value    <= id_nxt;
      ts_value    <= ts_nxt;
      avm_read    <= read_nxt;
      avm_address <= addr_nxt;
    end
  end

endmodule
